// File: rtl/lisp_pkg.sv
// Shared types for the cons-list walker. The element-count limit is compiled in only
// when LIST_WALKER_LEN_LIMIT_EN is defined.
package lisp_pkg;

  typedef logic [15:0] word_t;
  typedef logic [11:0] addr_t;

  localparam word_t NIL_PTR         = 16'h0000;
  localparam addr_t MAX_LEN_DEFAULT = 12'd4095;

`ifdef LIST_WALKER_LEN_LIMIT_EN
  localparam bit LEN_LIMIT_EN = 1'b1;
`else
  localparam bit LEN_LIMIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_RD_CAR = 3'd2,
    ST_EMIT   = 3'd3,
    ST_RD_CDR = 3'd4,
    ST_DONE   = 3'd5
  } walker_state_e;

  // The cdr word sits right after the car; the 12-bit add wraps 12'hFFF to 12'h000.
  function automatic addr_t cdr_addr(input addr_t car_a);
    return car_a + 12'd1;
  endfunction

endpackage

// File: rtl/list_walker.sv
// Follows a cons-list cdr chain to NIL, streaming each car on a valid/ready port.
// Defining LIST_WALKER_LEN_LIMIT_EN bounds the walk to MAX_LEN cars and flags err.
module list_walker
  import lisp_pkg::*;
#(
  parameter addr_t MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] head_ptr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [11:0] count,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_data_ready,
  input  logic [15:0] mem_data,
  output logic        car_valid,
  output logic [15:0] car_data,
  input  logic        car_ready,
  output logic [2:0]  dbg_state
);

  // Handshakes: a car transfers on a cycle with car_valid && car_ready; car_valid and
  // car_data hold until then. mem_req is a level held with a stable mem_addr until the
  // one-cycle mem_data_ready strobe, and drops on the following cycle.

  walker_state_e r_state, w_state_nxt;
  word_t         r_cur_ptr, w_cur_ptr_nxt;
  addr_t         r_count, w_count_nxt;
  logic          r_err, w_err_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_mem_req, w_mem_req_nxt;
  addr_t         r_mem_addr, w_mem_addr_nxt;
  logic          r_car_valid, w_car_valid_nxt;
  word_t         r_car_data, w_car_data_nxt;
  logic          w_limit_hit;

  assign w_limit_hit = LEN_LIMIT_EN && (r_count == (MAX_LEN - 12'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cur_ptr   <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_car_valid <= 1'b0;
      r_car_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_ptr   <= w_cur_ptr_nxt;
      r_count     <= w_count_nxt;
      r_err       <= w_err_nxt;
      r_busy      <= w_busy_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_car_valid <= w_car_valid_nxt;
      r_car_data  <= w_car_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_ptr_nxt   = r_cur_ptr;
    w_count_nxt     = r_count;
    w_err_nxt       = r_err;
    w_busy_nxt      = r_busy;
    w_mem_req_nxt   = r_mem_req;
    w_mem_addr_nxt  = r_mem_addr;
    w_car_valid_nxt = r_car_valid;
    w_car_data_nxt  = r_car_data;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_cur_ptr_nxt = head_ptr;
          w_count_nxt   = '0;
          w_err_nxt     = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_cur_ptr == NIL_PTR) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = r_cur_ptr[11:0];
          w_state_nxt    = ST_RD_CAR;
        end
      end
      ST_RD_CAR: begin
        if (mem_data_ready) begin
          w_car_data_nxt  = mem_data;
          w_mem_req_nxt   = 1'b0;
          w_car_valid_nxt = 1'b1;
          w_state_nxt     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (car_ready) begin
          w_car_valid_nxt = 1'b0;
          w_count_nxt     = r_count + 12'd1;
          // A list still running at the limit is treated as cyclic/corrupt.
          if (w_limit_hit) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = cdr_addr(r_cur_ptr[11:0]);
            w_state_nxt    = ST_RD_CDR;
          end
        end
      end
      ST_RD_CDR: begin
        if (mem_data_ready) begin
          w_cur_ptr_nxt = mem_data;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = ST_CHECK;
        end
      end
      ST_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy      = r_busy;
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign count     = r_count;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign car_valid = r_car_valid;
  assign car_data  = r_car_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_list_walker.sv
// Directed and randomized checks of list_walker against a list-following reference model.
`timescale 1ns/1ps
module tb_list_walker;
  import lisp_pkg::*;

`ifdef LIST_WALKER_LEN_LIMIT_EN
  localparam logic [11:0] TB_MAX_LEN = 12'd4;
  localparam bit          TB_LIMIT   = 1'b1;
`else
  localparam logic [11:0] TB_MAX_LEN = 12'd4095;
  localparam bit          TB_LIMIT   = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] head_ptr = '0;
  logic        busy, done, err, mem_req, car_valid;
  logic [11:0] count, mem_addr;
  logic        mem_data_ready = 1'b0;
  logic [15:0] mem_data = '0;
  logic [15:0] car_data;
  logic        car_ready = 1'b0;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  list_walker #(.MAX_LEN(TB_MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .head_ptr(head_ptr),
    .busy(busy), .done(done), .err(err), .count(count),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data_ready(mem_data_ready), .mem_data(mem_data),
    .car_valid(car_valid), .car_data(car_data), .car_ready(car_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] mem [4096];
  logic [15:0] exp_q[$];
  logic [11:0] exp_addr_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_cars = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: first car held off 5 cycles
  int late_req = 0;
  int late_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_car_valid"}, car_valid, 0);
    check({tag, "_car_data"}, car_data, 0);
  endtask

  // Reference model: follow the chain in the memory image, queueing every read address
  // and every car the walker should produce.
  task automatic build_expected(input logic [15:0] head, output int n, output logic e);
    logic [15:0] p;
    logic [11:0] a;
    p = head; n = 0; e = 1'b0;
    while (p != 16'h0000 && n < 5000) begin
      exp_addr_q.push_back(p[11:0]);
      exp_q.push_back(mem[p[11:0]]);
      n++;
      if (TB_LIMIT && n == int'(TB_MAX_LEN)) begin
        e = 1'b1;
        break;
      end
      a = p[11:0] + 12'd1;
      exp_addr_q.push_back(a);
      p = mem[a];
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int          delay;
    logic        pend;
    logic [11:0] held;
    pend = 1'b0; delay = 0; held = '0;
    forever begin
      @(posedge clk); #1;
      mem_data_ready = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (late_req != late_done) begin
        late_done = late_req;
        mem_data_ready = 1'b1;
        mem_data = 16'hBEEF;
      end else begin
        if (!pend && mem_req) begin
          if (exp_addr_q.size() == 0) check("req_unexpected", mem_req, 0);
          else check("req_addr", mem_addr, exp_addr_q.pop_front());
          held = mem_addr; pend = 1'b1; delay = $urandom_range(0, 3);
        end
        if (pend) begin
          check("mem_req_held", mem_req, 1);
          check("mem_addr_stable", mem_addr, held);
          if (delay == 0) begin
            mem_data_ready = 1'b1;
            mem_data = mem[held];
            pend = 1'b0;
          end else begin
            delay--;
          end
        end
      end
    end
  end

  // ---------------- car consumer ----------------
  initial begin
    int held_cnt;
    held_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode != 2) held_cnt = 0;
      case (rdy_mode)
        1: car_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (car_valid && held_cnt < 5) begin
            car_ready = 1'b0;
            held_cnt++;
          end else begin
            car_ready = 1'b1;
          end
        end
        default: car_ready = 1'b1;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    logic        pv, pr, pm, pmr;
    logic [15:0] pd;
    pv = 0; pr = 0; pm = 0; pmr = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; pr = 0; pm = 0; pmr = 0;
      end else begin
        if (pv && !pr) begin
          check("car_valid_held", car_valid, 1);
          check("car_data_stable", car_data, pd);
        end
        if (pm && pmr) check("mem_req_drop", mem_req, 0);
        if (car_valid) check("mem_req_low_while_emit", mem_req, 0);
        if (car_valid && car_ready) begin
          n_cars++;
          if (exp_q.size() == 0) check("car_unexpected", car_valid, 0);
          else check("car_data", car_data, exp_q.pop_front());
        end
        pv = car_valid; pr = car_ready; pd = car_data; pm = mem_req; pmr = mem_data_ready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_walk(input logic [15:0] head, input string tag, input bit noisy);
    int   n, cyc, cars0;
    logic e;
    bit   seen;
    build_expected(head, n, e);
    cars0 = n_cars;
    @(posedge clk); #1;
    head_ptr = head; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; head_ptr = 16'($urandom);
    check({tag, "_busy_start"}, busy, 1);
    seen = 0; cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      if (done) begin
        seen = 1;
        start = noisy;
        break;
      end
      if (noisy) start = ($urandom_range(0, 3) == 0);
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_count"}, count, 32'(n % 4096));
    check({tag, "_err"}, err, e);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
    repeat (2) @(posedge clk); #1;
    check({tag, "_count_held"}, count, 32'(n % 4096));
    check({tag, "_cars_emitted"}, n_cars - cars0, n);
    check({tag, "_cars_left"}, exp_q.size(), 0);
    check({tag, "_reads_left"}, exp_addr_q.size(), 0);
  endtask

  task automatic make_random_list(input int len, output logic [15:0] head);
    bit          used [4096];
    logic [11:0] cells [$];
    logic [11:0] a;
    logic [15:0] p;
    for (int i = 0; i < 4096; i++) used[i] = 0;
    while (cells.size() < len) begin
      a = 12'($urandom);
      if (!used[a] && !used[12'(a + 12'd1)]) begin
        used[a] = 1; used[12'(a + 12'd1)] = 1;
        cells.push_back(a);
      end
    end
    p = 16'h0000;
    for (int i = len - 1; i >= 0; i--) begin
      mem[cells[i]] = 16'($urandom);
      mem[12'(cells[i] + 12'd1)] = p;
      p = {4'($urandom), cells[i]};
      if (p == 16'h0000) p = 16'h1000;
    end
    head = p;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] h;
    int          n, cyc;
    logic        e;
    bit          hit;

    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    check("reset_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // NIL head: done in the third cycle counting the start cycle, no traffic
    @(posedge clk); #1;
    head_ptr = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t1_busy_c2", busy, 1);
    check("t1_done_c2", done, 0);
    @(posedge clk); #1;
    check("t1_done_c3", done, 1);
    check("t1_count", count, 0);
    @(posedge clk); #1;
    check("t1_done_c4", done, 0);
    check("t1_busy_c4", busy, 0);
    check("t1_err", err, 0);

    // Two-element list
    mem[12'h010] = 16'hDEAD; mem[12'h011] = 16'h0020;
    mem[12'h020] = 16'h1234; mem[12'h021] = 16'h0000;
    rdy_mode = 0;
    run_walk(16'h0010, "t2", 0);

    // Same list with the first car stalled by the consumer
    rdy_mode = 2;
    run_walk(16'h0010, "t3", 0);
    rdy_mode = 0;

    // Cell at the top of the address space; its cdr read wraps to 12'h000
    mem[12'hFFF] = 16'hCAFE; mem[12'h000] = 16'h0000;
    run_walk(16'h0FFF, "t4", 0);

    // Reset in the middle of a cdr read, stray strobe afterwards, then a clean walk
    make_random_list(4, h);
    build_expected(h, n, e);
    @(posedge clk); #1;
    head_ptr = h; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0; cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (dbg_state == 3'(ST_RD_CDR)) begin
        hit = 1;
        break;
      end
    end
    check("t5_reached_rd_cdr", hit, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_mid_reset");
    exp_q.delete(); exp_addr_q.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    late_req++;
    repeat (3) begin
      @(posedge clk); #1;
      check("t5_idle_busy", busy, 0);
      check("t5_idle_mem_req", mem_req, 0);
      check("t5_idle_car_valid", car_valid, 0);
      check("t5_idle_car_data", car_data, 0);
    end
    run_walk(h, "t5_restart", 0);

`ifdef LIST_WALKER_LEN_LIMIT_EN
    // Self-referencing cell bounded by the length limit
    mem[12'h100] = 16'h5A5A; mem[12'h101] = 16'h0100;
    run_walk(16'h0100, "t6", 0);
`endif

    // Randomized lists, back-pressure and stray start pulses while busy
    rdy_mode = 1;
    for (int t = 0; t < 20; t++) begin
      make_random_list($urandom_range(0, 8), h);
      run_walk(h, $sformatf("rnd%0d", t), 1);
    end
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
